booth_r4_datapath: RTL and testbench



---
 rtl/booth_r4_datapath.sv | 136 +++++++++++++
 tb/tb_booth_r4_datapath.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/booth_r4_datapath.sv
// booth_r4_datapath
// Datapath for a signed 8x8 radix-4 Booth multiplier. It obeys the one-hot
// control strobes c0..c7 from the Booth sequencer and returns the recoding
// bits {q1,q0,q} and the is_count_3 flag that the sequencer branches on.
// Operands arrive on inbus (multiplicand, then multiplier). The 16-bit
// product leaves on the registered outbus (high byte, then low byte).
//
// Optional feature: define BOOTH_DP_PROTOCOL_CHK_EN to add a sticky err
// output that flags illegal strobe combinations. With the macro undefined
// there is no err port and no check logic.

module booth_r4_datapath (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inbus,
    input  logic       c0,
    input  logic       c1,
    input  logic       c2,
    input  logic       c3,
    input  logic       c4,
    input  logic       c5,
    input  logic       c6,
    input  logic       c7,
`ifdef BOOTH_DP_PROTOCOL_CHK_EN
    output logic       err,
`endif
    output logic [7:0] outbus,
    output logic       q1,
    output logic       q0,
    output logic       q,
    output logic       is_count_3
);

    // Architectural registers
    logic [7:0] m_reg;    // multiplicand, signed
    logic [9:0] a_reg;    // accumulator, 2 guard bits so +/-2M never overflows
    logic [7:0] q_reg;    // multiplier, becomes the product low byte
    logic       qm1_reg;  // q(-1)
    logic [1:0] cnt;      // iteration counter, wraps 3 -> 0

    // Combinational next values
    logic [9:0] op;       // sign-extended M or 2M
    logic [9:0] a_add;    // accumulator after the optional add/subtract
    logic [9:0] a_shf;    // a_add arithmetically shifted right by 2
    logic [7:0] q_shf;    // Q with the two bits leaving A shifted in

    // Operand select, add/subtract, then shift; c2 with c5 shifts the post-add value
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        op    = c3 ? {m_reg[7], m_reg, 1'b0} : {{2{m_reg[7]}}, m_reg};
        a_add = a_reg;
        if (c2) begin
            a_add = c4 ? (a_reg - op) : (a_reg + op);
        end
        a_shf = {{2{a_add[9]}}, a_add[9:2]};
        q_shf = {a_add[1:0], q_reg[7:2]};
    end

    // Register update; loads (c0/c1) take priority over add/shift on what they write
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reg   <= 8'h00;
            a_reg   <= 10'h000;
            q_reg   <= 8'h00;
            qm1_reg <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            if (c0) begin
                m_reg <= inbus;
                a_reg <= 10'h000;
            end else if (c5) begin
                a_reg <= a_shf;
            end else if (c2) begin
                a_reg <= a_add;
            end

            if (c1) begin
                q_reg   <= inbus;
                qm1_reg <= 1'b0;
                cnt     <= 2'd0;
            end else if (c5) begin
                q_reg   <= q_shf;
                qm1_reg <= q_reg[1];
                cnt     <= cnt + 2'd1;
            end
        end
    end

    // Registered output bus; c7 wins over c6, otherwise it holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outbus <= 8'h00;
        end else if (c7) begin
            outbus <= q_reg;
        end else if (c6) begin
            outbus <= a_reg[7:0];
        end
    end

    assign q1         = q_reg[1];
    assign q0         = q_reg[0];
    assign q          = qm1_reg;
    assign is_count_3 = (cnt == 2'd3);

`ifdef BOOTH_DP_PROTOCOL_CHK_EN
    logic [2:0] n_active;    // number of active strobe groups this cycle
    logic       wrap_seen;   // the 4th shift happened and no reload yet
    logic       violation;

    // Detect illegal strobe combinations in the current cycle
    always_comb begin
        n_active  = {2'b00, c0 | c1} + {2'b00, c2} + {2'b00, c5}
                  + {2'b00, c6} + {2'b00, c7};
        violation = (n_active > 3'd1)
                  | ((c3 | c4) & ~c2)
                  | (c5 & wrap_seen);
    end

    // Arm on the wrapping shift, disarm on reload; err is sticky until rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_seen <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (c1) begin
                wrap_seen <= 1'b0;
            end else if (c5 && (cnt == 2'd3)) begin
                wrap_seen <= 1'b1;
            end
            err <= err | violation;
        end
    end
`endif

endmodule

// File: tb/tb_booth_r4_datapath.sv
// tb_booth_r4_datapath
// Directed bench for booth_r4_datapath. The bench plays the sequencer role:
// it derives each Booth digit from the multiplier operand it loaded and
// drives the matching strobes. It checks the recoding bits, the count flag
// and the product bytes against hand-computed values. Build with
// BOOTH_DP_PROTOCOL_CHK_EN defined to also exercise the err output.

module tb_booth_r4_datapath;

    localparam logic [7:0] C0 = 8'h01;
    localparam logic [7:0] C1 = 8'h02;
    localparam logic [7:0] C2 = 8'h04;
    localparam logic [7:0] C3 = 8'h08;
    localparam logic [7:0] C4 = 8'h10;
    localparam logic [7:0] C5 = 8'h20;
    localparam logic [7:0] C6 = 8'h40;
    localparam logic [7:0] C7 = 8'h80;

    logic       clk;
    logic       rst;
    logic [7:0] inbus;
    logic       c0, c1, c2, c3, c4, c5, c6, c7;
    logic [7:0] outbus;
    logic       q1, q0, q, is_count_3;
`ifdef BOOTH_DP_PROTOCOL_CHK_EN
    logic       err;
`endif

    int checks   = 0;
    int failures = 0;

    booth_r4_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .inbus      (inbus),
        .c0         (c0),
        .c1         (c1),
        .c2         (c2),
        .c3         (c3),
        .c4         (c4),
        .c5         (c5),
        .c6         (c6),
        .c7         (c7),
`ifdef BOOTH_DP_PROTOCOL_CHK_EN
        .err        (err),
`endif
        .outbus     (outbus),
        .q1         (q1),
        .q0         (q0),
        .q          (q),
        .is_count_3 (is_count_3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold the given strobes for one clock, then release them; returns 1 time unit after the edge.
    task automatic strobe(input logic [7:0] c, input logic [7:0] bus);
        {c7, c6, c5, c4, c3, c2, c1, c0} = c;
        inbus = bus;
        @(posedge clk);
        #1;
        {c7, c6, c5, c4, c3, c2, c1, c0} = 8'h00;
    endtask

    // Full nominal sequence: load, 4 x (optional add, shift), read out.
    task automatic run_mult(input string name, input logic [7:0] mv, input logic [7:0] qv,
                            input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        logic [2:0] bits;
        logic [7:0] ctl;
        strobe(C0, mv);
        strobe(C1, qv);
        for (int i = 0; i < 4; i++) begin
            bits = {qv[2*i+1], qv[2*i], (i == 0) ? 1'b0 : qv[2*i-1]};
            check($sformatf("%s_bits%0d", name, i), {13'd0, q1, q0, q}, {13'd0, bits});
            check($sformatf("%s_cnt3_%0d", name, i), {15'd0, is_count_3}, {15'd0, (i == 3)});
            case (bits)
                3'b001, 3'b010: ctl = C2;
                3'b011:         ctl = C2 | C3;
                3'b100:         ctl = C2 | C3 | C4;
                3'b101, 3'b110: ctl = C2 | C4;
                default:        ctl = 8'h00;
            endcase
            if (ctl != 8'h00) strobe(ctl, 8'h00);
            strobe(C5, 8'h00);
        end
        check({name, "_cnt_wrap"}, {15'd0, is_count_3}, 16'd0);
        strobe(C6, 8'h00);
        check({name, "_hi"}, {8'd0, outbus}, {8'd0, exp_hi});
        check({name, "_guard"}, {14'd0, dut.a_reg[9:8]}, {14'd0, {2{exp_hi[7]}}});
        strobe(C7, 8'h00);
        check({name, "_lo"}, {8'd0, outbus}, {8'd0, exp_lo});
    endtask

    initial begin
        rst   = 1'b1;
        inbus = 8'h00;
        {c7, c6, c5, c4, c3, c2, c1, c0} = 8'h00;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_outbus", {8'd0, outbus}, 16'h0000);
        check("rst_bits", {13'd0, q1, q0, q}, 16'h0000);
        check("rst_cnt3", {15'd0, is_count_3}, 16'h0000);

        // Counter: is_count_3 only after the 3rd shift, wraps after the 4th
        strobe(C1, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            strobe(C5, 8'h00);
            check($sformatf("cnt_after_%0d", i), {15'd0, is_count_3}, {15'd0, (i == 3)});
        end

        // Mid-cycle async reset with nonzero registers
        strobe(C1, 8'hFF);
        strobe(C5, 8'h00);
        strobe(C5, 8'h00);
        strobe(C5, 8'h00);
        strobe(C7, 8'h00);
        check("pre_rst_outbus", {8'd0, outbus}, 16'h0003);
        check("pre_rst_bits", {13'd0, q1, q0, q}, 16'h0007);
        check("pre_rst_cnt3", {15'd0, is_count_3}, 16'h0001);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outbus", {8'd0, outbus}, 16'h0000);
        check("async_rst_bits", {13'd0, q1, q0, q}, 16'h0000);
        check("async_rst_cnt3", {15'd0, is_count_3}, 16'h0000);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Products
        run_mult("pos",  8'h07, 8'h03, 8'h00, 8'h15);  // 7 * 3 = 21
        run_mult("mix",  8'hFB, 8'h06, 8'hFF, 8'hE2);  // -5 * 6 = -30
        run_mult("min2", 8'h80, 8'h80, 8'h40, 8'h00);  // -128 * -128 = 16384
        run_mult("maxm", 8'h7F, 8'h80, 8'hC0, 8'h80);  // 127 * -128 = -16256

`ifdef BOOTH_DP_PROTOCOL_CHK_EN
        check("err_clean_run", {15'd0, err}, 16'h0000);
`endif

        // c6 alone reads A, c6 with c7 reads Q
        strobe(C6, 8'h00);
        check("c6_only", {8'd0, outbus}, 16'h00C0);
        strobe(C6 | C7, 8'h00);
        check("c6_c7_c7wins", {8'd0, outbus}, 16'h0080);

`ifdef BOOTH_DP_PROTOCOL_CHK_EN
        check("err_c6_c7", {15'd0, err}, 16'h0001);
        strobe(8'h00, 8'h00);
        strobe(8'h00, 8'h00);
        check("err_sticky", {15'd0, err}, 16'h0001);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("err_cleared", {15'd0, err}, 16'h0000);
        strobe(C4, 8'h00);
        check("err_c4_no_c2", {15'd0, err}, 16'h0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
